// File: rtl/phase_accumulator_if.sv
// rtl/phase_accumulator_if.sv - frequency-word input and phase output streams of the phase accumulator
interface phase_accumulator_if #(
    parameter int ACC_DW   = 32,
    parameter int PHASE_DW = 16
);
    logic [ACC_DW-1:0]   s_axis_freq_tdata;
    logic                s_axis_freq_tvalid;
    logic                s_axis_freq_tready;
    logic [PHASE_DW-1:0] m_axis_phase_tdata;
    logic                m_axis_phase_tvalid;

    // master: the side feeding tuning words and consuming phase samples
    modport master (
        output s_axis_freq_tdata,
        output s_axis_freq_tvalid,
        input  s_axis_freq_tready,
        input  m_axis_phase_tdata,
        input  m_axis_phase_tvalid
    );

    // slave: the phase accumulator itself
    modport slave (
        input  s_axis_freq_tdata,
        input  s_axis_freq_tvalid,
        output s_axis_freq_tready,
        output m_axis_phase_tdata,
        output m_axis_phase_tvalid
    );
endinterface

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - DDS phase accumulator with linear frequency sweep and phase offset
// Optional truncation dither is enabled by defining PHASE_DITHER_EN.
module phase_accumulator #(
    parameter int PHASE_DW = 16,
    parameter int ACC_DW   = 32,
    parameter int CNT_DW   = 16
) (
    input  logic               clk,
    input  logic               reset,
    phase_accumulator_if.slave axis,
    input  logic [ACC_DW-1:0]  cfg_phase_offset,
    input  logic [ACC_DW-1:0]  cfg_sweep_step,
    input  logic [CNT_DW-1:0]  cfg_sweep_len,
    input  logic               start,
    input  logic               stop,
    input  logic               sync,
    output logic               busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ACC_DW-1:0]   acc;
    logic [ACC_DW-1:0]   freq;
    logic [ACC_DW-1:0]   step_q;
    logic [ACC_DW-1:0]   phase_sum;
    logic [CNT_DW-1:0]   cnt;
    logic [PHASE_DW-1:0] tdata_q;
    logic                tvalid_q;
    logic                tready_q;
    logic                accept;
    logic                active;
    logic                enter_sweep;

    assign accept      = axis.s_axis_freq_tvalid & tready_q;
    assign active      = (state != IDLE);
    assign enter_sweep = (state_next == SWEEP) && (state != SWEEP);
    assign busy        = active;

    assign axis.s_axis_freq_tready  = tready_q;
    assign axis.m_axis_phase_tdata  = tdata_q;
    assign axis.m_axis_phase_tvalid = tvalid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop wins over start; a running sweep ignores further start requests
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = IDLE;
        end else if (start && (state != SWEEP)) begin
            state_next = (cfg_sweep_len != '0) ? SWEEP : RUN;
        end else if ((state == SWEEP) && (cnt == CNT_DW'(1))) begin
            state_next = RUN;
        end
    end

`ifdef PHASE_DITHER_EN
    localparam int                DITHER_BITS = ACC_DW - PHASE_DW;
    localparam logic [ACC_DW-1:0] DITHER_MASK = (ACC_DW'(1) << DITHER_BITS) - ACC_DW'(1);

    logic [15:0] lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, stepped once per output sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (active) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign phase_sum = acc + cfg_phase_offset + (ACC_DW'(lfsr) & DITHER_MASK);
`else
    assign phase_sum = acc + cfg_phase_offset;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            freq     <= '0;
            step_q   <= '0;
            cnt      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            tready_q <= (state_next != SWEEP);
            tvalid_q <= active;
            if (active) begin
                tdata_q <= PHASE_DW'(phase_sum >> (ACC_DW - PHASE_DW));
            end

            if (sync) begin
                acc <= '0;
            end else if (active) begin
                acc <= acc + freq;
            end

            // a word accepted together with start becomes the sweep's initial frequency
            if (enter_sweep) begin
                cnt    <= cfg_sweep_len;
                step_q <= cfg_sweep_step;
                if (accept) begin
                    freq <= axis.s_axis_freq_tdata;
                end
            end else if (state == SWEEP) begin
                freq <= freq + step_q;
                cnt  <= cnt - CNT_DW'(1);
            end else if (accept) begin
                freq <= axis.s_axis_freq_tdata;
            end
        end
    end
endmodule

// File: doc/phase_accumulator.md
PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
- REQ-001 SHALL have parameter PHASE_DW, default 16: output phase width, matching the downstream dds PHASE_DW.
- REQ-002 SHALL have parameter ACC_DW, default 32: accumulator and frequency-word width; ACC_DW >= PHASE_DW.
- REQ-003 SHALL have parameter CNT_DW, default 16: sweep-length counter width.
- REQ-004 SHALL have port clk, input, 1: single clock.
- REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-006 SHALL have port s_axis_freq_tdata, input, ACC_DW: unsigned frequency tuning word.
- REQ-007 SHALL have port s_axis_freq_tvalid, input, 1: tuning word valid.
- REQ-008 SHALL have port s_axis_freq_tready, output, 1: tuning word accepted when tvalid&tready.
- REQ-009 SHALL have port cfg_phase_offset, input, ACC_DW: static phase offset added before truncation.
- REQ-010 SHALL have port cfg_sweep_step, input, ACC_DW: signed per-sample frequency increment.
- REQ-011 SHALL have port cfg_sweep_len, input, CNT_DW: number of sweep samples; 0 means no sweep.
- REQ-012 SHALL have port start, input, 1: one-cycle run/sweep request.
- REQ-013 SHALL have port stop, input, 1: one-cycle halt request.
- REQ-014 SHALL have port sync, input, 1: one-cycle accumulator clear.
- REQ-015 SHALL have port m_axis_phase_tdata, output, PHASE_DW: phase to dds s_axis_phase_tdata.
- REQ-016 SHALL have port m_axis_phase_tvalid, output, 1: phase valid to dds s_axis_phase_tvalid.
- REQ-017 SHALL have port busy, output, 1: high in RUN or SWEEP.

Function
- REQ-018 SHALL implement FSM states IDLE, RUN, SWEEP; IDLE->SWEEP on start with cfg_sweep_len!=0, IDLE/RUN->RUN on start with cfg_sweep_len==0, RUN->SWEEP on start with len!=0, any->IDLE on stop.
- REQ-019 SHALL give stop priority over start in the same cycle.
- REQ-020 SHALL assert s_axis_freq_tready in IDLE and RUN, deassert in SWEEP; an accepted word loads freq register next cycle.
- REQ-021 SHALL, when a word is accepted in the same cycle as start, use the new word as the initial frequency.
- REQ-022 SHALL, in RUN and SWEEP, update acc <= acc + freq modulo 2^ACC_DW every cycle; in IDLE acc holds.
- REQ-023 SHALL, on entering SWEEP, load counter with cfg_sweep_len (latched); each SWEEP cycle freq <= freq + cfg_sweep_step (mod 2^ACC_DW, latched at start) and counter decrements; at counter==1 go to RUN holding the final freq.
- REQ-024 SHALL register m_axis_phase_tdata = (acc_current + cfg_phase_offset)[ACC_DW-1 -: PHASE_DW], where acc_current is the pre-increment value, one cycle latency.
- REQ-025 SHALL assert m_axis_phase_tvalid the cycle after any cycle in RUN or SWEEP; first valid sample appears 2 cycles after start.
- REQ-026 SHALL, on sync, set acc to 0 next cycle, overriding the increment; FSM state unaffected.
- REQ-027 SHALL ignore start while already in SWEEP (sweep is not restarted).

Reset
- REQ-028 SHALL, on reset asserted, immediately drive state IDLE, acc 0, freq 0, counter 0, m_axis_phase_tdata 0, m_axis_phase_tvalid 0, busy 0, s_axis_freq_tready 0.
- REQ-029 SHALL assert s_axis_freq_tready the first clock after reset deasserts; reset mid-sweep discards sweep entirely.

Configuration
- REQ-030 SHALL, with macro PHASE_DITHER_EN defined, add a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1, advancing every valid cycle) masked to its low ACC_DW-PHASE_DW bits to the sum before truncation; requires ACC_DW-PHASE_DW <= 16.
- REQ-031 SHALL, without PHASE_DITHER_EN, truncate plainly with no LFSR logic.

Verification (PHASE_DW=16, ACC_DW=32, dither off)
- REQ-032 SHALL cover: freq 0x0100_0000, offset 0, start -> tvalid at cycle 2, tdata 0x0000, 0x0100, 0x0200, ...
- REQ-033 SHALL cover: freq 0x4000_0000 -> tdata 0x0000, 0x4000, 0x8000, 0xC000, 0x0000 (wrap).
- REQ-034 SHALL cover: freq 0, step 0x0001_0000, len 4, start -> tdata 0, 0, 1, 3, 6, 10, 14; tready low for exactly 4 cycles; then RUN at freq 0x0004_0000.
- REQ-035 SHALL cover: start and stop in the same cycle during RUN -> IDLE, tvalid 0 one cycle later, tdata holds.
- REQ-036 SHALL cover: sync during RUN at freq 0x1000_0000 -> post-sync sequence restarts 0x0000, 0x1000, ...
- REQ-037 SHALL cover: reset asserted mid-sweep -> all outputs 0 immediately; after release, start with len 0 yields an unswept RUN from acc 0.
